regpair_ctrl: RTL and testbench

Register-pair access sequencer and command-side initiator for the 8-bit registerfile. It accepts 16-bit pair commands (read, write, increment, decrement) from the control unit and produces the per-port enable and address sequence the registerfile responds to. It sits between the 8085 control unit and the registerfile, and serves the BC/DE/HL-style pair operations such as LXI, INX and DCX.

---
 rtl/regpair_ctrl.sv | 169 ++++++++++++++++
 tb/tb_regpair_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regpair_ctrl.sv
// Register-pair sequencer: turns 16-bit pair commands (READ/WRITE/INX/DCX)
// into the registerfile's read-port and write-port access sequence.
module regpair_ctrl #(
    parameter int DATASIZE = 8,
    parameter int REGBIT   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [REGBIT-2:0]       cmd_pair,
    input  logic [2*DATASIZE-1:0]   cmd_data,
    output logic                    rsp_valid,
    output logic [2*DATASIZE-1:0]   rsp_data,
    output logic                    wrenb,
    output logic [REGBIT-1:0]       waddr,
    output logic [DATASIZE-1:0]     wdata,
    output logic                    r1enb,
    output logic [REGBIT-1:0]       r1add,
    output logic                    r2enb,
    output logic [REGBIT-1:0]       r2add,
    input  logic [DATASIZE-1:0]     r1dat,
    input  logic [DATASIZE-1:0]     r2dat
);

    localparam int PW = 2 * DATASIZE;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INX   = 2'b10;
    localparam logic [1:0] OP_DCX   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDREQ,
        S_RDCAP,
        S_WRHI,
        S_WRLO,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [1:0]            r_op;
    logic [REGBIT-2:0]     r_pair;
    logic [PW-1:0]         r_value;
    logic                  r_cmdReady;
    logic                  r_rspValid;
    logic [PW-1:0]         r_rspData;
    logic                  r_wrEnb;
    logic [REGBIT-1:0]     r_wAddr;
    logic [DATASIZE-1:0]   r_wData;
    logic                  r_rdEnb;
    logic [REGBIT-1:0]     r_r1Add;
    logic [REGBIT-1:0]     r_r2Add;

    logic [PW-1:0]         w_capture;
    logic [PW-1:0]         w_adjusted;
    logic [PW-1:0]         w_one;
    logic [REGBIT-1:0]     w_addrHi;
    logic [REGBIT-1:0]     w_addrLo;

    assign w_one     = PW'(1);
    assign w_capture = {r1dat, r2dat};
    assign w_addrHi  = {r_pair, 1'b0};
    assign w_addrLo  = {r_pair, 1'b1};

    always_comb begin
        w_adjusted = w_capture + w_one;
        if (r_op == OP_DCX) begin
            w_adjusted = w_capture - w_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= OP_READ;
            r_pair     <= '0;
            r_value    <= '0;
            r_cmdReady <= 1'b1;
            r_rspValid <= 1'b0;
            r_rspData  <= '0;
            r_wrEnb    <= 1'b0;
            r_wAddr    <= '0;
            r_wData    <= '0;
            r_rdEnb    <= 1'b0;
            r_r1Add    <= '0;
            r_r2Add    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op       <= cmd_op;
                        r_pair     <= cmd_pair;
                        r_value    <= cmd_data;
                        r_cmdReady <= 1'b0;
                        if (cmd_op == OP_WRITE) begin
                            r_state <= S_WRHI;
                            r_wrEnb <= 1'b1;
                            r_wAddr <= {cmd_pair, 1'b0};
                            r_wData <= cmd_data[PW-1:DATASIZE];
                        end else begin
                            r_state <= S_RDREQ;
                            r_rdEnb <= 1'b1;
                            r_r1Add <= {cmd_pair, 1'b0};
                            r_r2Add <= {cmd_pair, 1'b1};
                        end
                    end
                end
                S_RDREQ: begin
                    r_rdEnb <= 1'b0;
                    r_state <= S_RDCAP;
                end
                // Read data from the RDREQ cycle is on r1dat/r2dat now.
                S_RDCAP: begin
                    if (r_op == OP_READ) begin
                        r_value    <= w_capture;
                        r_rspData  <= w_capture;
                        r_rspValid <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_value <= w_adjusted;
                        r_wrEnb <= 1'b1;
                        r_wAddr <= w_addrHi;
                        r_wData <= w_adjusted[PW-1:DATASIZE];
                        r_state <= S_WRHI;
                    end
                end
                S_WRHI: begin
                    r_wAddr <= w_addrLo;
                    r_wData <= r_value[DATASIZE-1:0];
                    r_state <= S_WRLO;
                end
                S_WRLO: begin
                    r_wrEnb    <= 1'b0;
                    r_rspData  <= r_value;
                    r_rspValid <= 1'b1;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    r_rspValid <= 1'b0;
                    r_cmdReady <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_cmdReady <= 1'b1;
                    r_rspValid <= 1'b0;
                    r_wrEnb    <= 1'b0;
                    r_rdEnb    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmdReady;
    assign rsp_valid = r_rspValid;
    assign rsp_data  = r_rspData;
    // Masking with rst keeps a pending write from committing on the reset edge.
    assign wrenb     = r_wrEnb & ~rst;
    assign waddr     = r_wAddr;
    assign wdata     = r_wData;
    assign r1enb     = r_rdEnb;
    assign r2enb     = r_rdEnb;
    assign r1add     = r_r1Add;
    assign r2add     = r_r2Add;

endmodule

// File: tb/tb_regpair_ctrl.sv
// Bench for regpair_ctrl with a behavioural 8x8 registerfile and a
// scoreboard monitor that checks response data and latency.
module tb_regpair_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_pair;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        wrenb;
    logic [2:0]  waddr;
    logic [7:0]  wdata;
    logic        r1enb;
    logic [2:0]  r1add;
    logic        r2enb;
    logic [2:0]  r2add;
    logic [7:0]  r1dat;
    logic [7:0]  r2dat;

    logic [7:0]  regs [0:7] = '{default: 8'h00};

    typedef struct {
        logic [15:0] data;
        int          cycle;
    } exp_t;

    exp_t sbQueue [$];

    int cycleCount = 0;
    int checkCount = 0;
    int passCount  = 0;
    int rdEnCount  = 0;
    int wrEnCount  = 0;
    int wrCycle [0:7] = '{default: 0};
    logic prevRsp = 1'b0;

    regpair_ctrl #(.DATASIZE(8), .REGBIT(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_pair(cmd_pair), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .wrenb(wrenb), .waddr(waddr), .wdata(wdata),
        .r1enb(r1enb), .r1add(r1add), .r2enb(r2enb), .r2add(r2add),
        .r1dat(r1dat), .r2dat(r2dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Registerfile model: synchronous write, one-cycle registered reads.
    always @(posedge clk) begin
        if (wrenb) regs[waddr] <= wdata;
        if (r1enb) r1dat <= regs[r1add];
        if (r2enb) r2dat <= regs[r2add];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            checkOutput("port exclusivity", {31'd0, wrenb && (r1enb || r2enb)}, 32'd0);
            checkOutput("rsp single pulse", {31'd0, rsp_valid && prevRsp}, 32'd0);
        end
        prevRsp <= rsp_valid;
        if (r1enb || r2enb) rdEnCount <= rdEnCount + 1;
        if (wrenb) begin
            wrEnCount <= wrEnCount + 1;
            wrCycle[waddr] <= cycleCount;
        end
        if (rsp_valid) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected rsp", 32'd1, 32'd0);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("rsp data", {16'd0, rsp_data}, {16'd0, e.data});
                checkOutput("rsp latency", cycleCount, e.cycle);
            end
        end
    end

    // Caller is positioned just after a rising edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] pair, input logic [15:0] data,
                                 input logic [15:0] expData, input int latency, input string name);
        int waitCycles = 0;
        while (!cmd_ready && waitCycles < 20) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        if (!cmd_ready) begin
            checkOutput({name, " accept timeout"}, 32'd0, 32'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_pair  = pair;
        cmd_data  = data;
        sbQueue.push_back('{expData, cycleCount + latency});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int waitCycles = 0;
        while (sbQueue.size() != 0 && waitCycles < 30) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        checkOutput({name, " drained"}, sbQueue.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int k;
        int rdBase;
        int wrBase;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_pair  = 2'b00;
        cmd_data  = 16'h0000;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset enables", {29'd0, wrenb, r1enb, r2enb}, 32'd0);
        checkOutput("reset addrs", {23'd0, waddr, r1add, r2add}, 32'd0);
        checkOutput("reset rsp_data", {16'd0, rsp_data}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(2'b01, 2'd0, 16'hA55A, 16'hA55A, 3, "WRITE p0");
        waitDrain("WRITE p0");
        applyStimulus(2'b00, 2'd0, 16'h0000, 16'hA55A, 3, "READ p0");
        waitDrain("READ p0");
        checkOutput("reg0", {24'd0, regs[0]}, 32'hA5);
        checkOutput("reg1", {24'd0, regs[1]}, 32'h5A);

        applyStimulus(2'b01, 2'd2, 16'hFFFF, 16'hFFFF, 3, "WRITE p2");
        waitDrain("WRITE p2");
        applyStimulus(2'b10, 2'd2, 16'h0000, 16'h0000, 5, "INX p2");
        waitDrain("INX p2");
        checkOutput("reg4", {24'd0, regs[4]}, 32'h00);
        checkOutput("reg5", {24'd0, regs[5]}, 32'h00);
        checkOutput("INX hi before lo", wrCycle[5] - wrCycle[4], 32'd1);

        applyStimulus(2'b01, 2'd1, 16'h0000, 16'h0000, 3, "WRITE p1 0000");
        applyStimulus(2'b11, 2'd1, 16'h0000, 16'hFFFF, 5, "DCX p1 0000");
        waitDrain("DCX p1 0000");
        checkOutput("reg2 after DCX", {24'd0, regs[2]}, 32'hFF);
        checkOutput("reg3 after DCX", {24'd0, regs[3]}, 32'hFF);
        checkOutput("DCX hi before lo", wrCycle[3] - wrCycle[2], 32'd1);

        applyStimulus(2'b01, 2'd1, 16'h1200, 16'h1200, 3, "WRITE p1 1200");
        applyStimulus(2'b11, 2'd1, 16'h0000, 16'h11FF, 5, "DCX p1 1200");
        waitDrain("DCX p1 1200");
        checkOutput("reg2 after DCX 1200", {24'd0, regs[2]}, 32'h11);
        checkOutput("reg3 after DCX 1200", {24'd0, regs[3]}, 32'hFF);

        // Held cmd_valid: second command waits until the cycle after RESP.
        checkOutput("held idle ready", {31'd0, cmd_ready}, 32'd1);
        k      = cycleCount;
        rdBase = rdEnCount;
        wrBase = wrEnCount;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_pair  = 2'd0;
        cmd_data  = 16'h0000;
        sbQueue.push_back('{16'hA55A, k + 3});
        sbQueue.push_back('{16'h1234, k + 7});
        @(posedge clk); #1;
        cmd_op   = 2'b01;
        cmd_pair = 2'd3;
        cmd_data = 16'h1234;
        for (int i = 1; i <= 3; i++) begin
            checkOutput("held busy ready", {31'd0, cmd_ready}, 32'd0);
            @(posedge clk); #1;
        end
        checkOutput("held second accept ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        waitDrain("held pair");
        checkOutput("reg6", {24'd0, regs[6]}, 32'h12);
        checkOutput("reg7", {24'd0, regs[7]}, 32'h34);
        checkOutput("held read enable cycles", rdEnCount - rdBase, 32'd1);
        checkOutput("held write enable cycles", wrEnCount - wrBase, 32'd2);
        checkOutput("held hi before lo", wrCycle[7] - wrCycle[6], 32'd1);

        // Reset while the low byte of a WRITE is pending.
        applyStimulus(2'b01, 2'd1, 16'h0000, 16'h0000, 3, "WRITE p1 clear");
        waitDrain("WRITE p1 clear");
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_pair  = 2'd1;
        cmd_data  = 16'hBEEF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("post-reset enables", {29'd0, wrenb, r1enb, r2enb}, 32'd0);
        checkOutput("post-reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("post-reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("reg2 after reset", {24'd0, regs[2]}, 32'hBE);
        checkOutput("reg3 after reset", {24'd0, regs[3]}, 32'h00);
        checkOutput("scoreboard empty", sbQueue.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
